mem_seq: RTL and testbench

MEM_SEQ -- requirements
Module: mem_seq

---
 rtl/mem_seq_pkg.sv | 23 ++
 rtl/wait_cnt.sv | 33 +++
 rtl/mem_seq.sv | 100 ++++++++++
 tb/tb_mem_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory-access sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: sequencer state encoding, default address width, wait-counter width.
package mem_seq_pkg;

   // Default memory address width; bus bits above this are an address fault.
   localparam int ADDR_W_DEF = 9;

   // Wait counter width; bounds the legal WAIT_CYCLES range to 0..7.
   localparam int CNT_W = 3;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_MAR     = 3'd1,
      S_RD      = 3'd2,
      S_WR_DATA = 3'd3,
      S_WR      = 3'd4,
      S_DONE    = 3'd5,
      S_ERR     = 3'd6
   } state_e;

endpackage

// File: rtl/wait_cnt.sv
// RAM wait-state counter: loads a fixed count, decrements to zero and holds there.
// Latency: load/dec take effect on the next clk edge; zero_o is a decode of the register.
// Backpressure: none; the sequencer decides when to load and decrement.
// Ports: clk_i clock, clr_ni async active-low clear, load_i load LOAD_VAL,
//        dec_i decrement (saturates at 0), zero_o count is zero.
module wait_cnt
   import mem_seq_pkg::*;
#(
   parameter logic [CNT_W-1:0] LOAD_VAL = '0
) (
   input  logic clk_i,
   input  logic clr_ni,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge clr_ni) begin
      if (!clr_ni) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= LOAD_VAL;
      end else if (dec_i && (cnt_q != '0)) begin
         // Stop at zero so a stray decrement can never wrap to 7.
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_seq.sv
// Memory-access sequencer: drives MAR/MDR load enables and RAM strobes for one load or store.
// Latency: load done WAIT_CYCLES+3 cycles after acceptance, store done WAIT_CYCLES+4.
// Backpressure: requests are sampled only in IDLE; requests while busy are dropped, not queued.
// Ports: clk clock, clr async active-low reset, req_rd/req_wr load/store requests,
//        bus shared CPU bus (address in MAR cycle, store data in WR_DATA cycle),
//        MARin/MDRin register load enables, read/write RAM strobes,
//        busy not-IDLE, done completion pulse, err error pulse (with done).
module mem_seq
   import mem_seq_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_W      = ADDR_W_DEF
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        req_rd,
   input  logic        req_wr,
   input  logic [31:0] bus,
   output logic        MARin,
   output logic        MDRin,
   output logic        read,
   output logic        write,
   output logic        busy,
   output logic        done,
   output logic        err
);

   // Only the low CNT_W bits are meaningful; legal WAIT_CYCLES is 0..7.
   localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

   state_e state_q;
   logic   is_wr_q;     // operation type latched at acceptance
   logic   addr_fault;
   logic   cnt_load;
   logic   cnt_dec;
   logic   cnt_zero;

   // Any bus bit above the address field marks an out-of-range address.
   assign addr_fault = |(bus >> ADDR_W);

   // Counter is loaded on the edge that enters RD or WR, so the first
   // strobe cycle sees WAIT_CYCLES and the last one sees zero.
   assign cnt_load = ((state_q == S_MAR) && !addr_fault && !is_wr_q) ||
                     (state_q == S_WR_DATA);
   assign cnt_dec  = (state_q == S_RD) || (state_q == S_WR);

   wait_cnt #(
      .LOAD_VAL (WAIT_LD)
   ) u_wait_cnt (
      .clk_i  (clk),
      .clr_ni (clr),
      .load_i (cnt_load),
      .dec_i  (cnt_dec),
      .zero_o (cnt_zero)
   );

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= S_IDLE;
         is_wr_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_rd && req_wr) begin
                  state_q <= S_ERR;
               end else if (req_rd || req_wr) begin
                  state_q <= S_MAR;
                  is_wr_q <= req_wr;
               end
            end
            S_MAR: begin
               if (addr_fault)   state_q <= S_ERR;
               else if (is_wr_q) state_q <= S_WR_DATA;
               else              state_q <= S_RD;
            end
            S_RD:      if (cnt_zero) state_q <= S_DONE;
            S_WR_DATA: state_q <= S_WR;
            S_WR:      if (cnt_zero) state_q <= S_DONE;
            S_DONE:    state_q <= S_IDLE;
            S_ERR:     state_q <= S_IDLE;
            default:   state_q <= S_IDLE;
         endcase
      end
   end

   // Moore decode from registered state (and registered count) only, so no
   // request or bus input ever reaches an output combinationally. Reset of
   // state_q forces every output low immediately.
   always_comb begin
      MARin = (state_q == S_MAR);
      read  = (state_q == S_RD);
      write = (state_q == S_WR);
      // In RD, MDR captures memory data only in the final strobe cycle.
      MDRin = ((state_q == S_RD) && cnt_zero) || (state_q == S_WR_DATA);
      busy  = (state_q != S_IDLE);
      done  = (state_q == S_DONE) || (state_q == S_ERR);
      err   = (state_q == S_ERR);
   end

endmodule

// File: tb/tb_mem_seq.sv
// Self-checking bench for mem_seq with WAIT_CYCLES=1, ADDR_W=9.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_seq;

   logic        clk = 1'b0;
   logic        clr;
   logic        req_rd;
   logic        req_wr;
   logic [31:0] bus;
   logic        MARin, MDRin, read, write, busy, done, err;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int lat;      // busy cycles from acceptance up to and including done
      int mar;
      int mar_pos;
      int rd;
      int mdr;
      int mdr_pos;
      int wr;
      int err;
      int ovl;      // any forbidden strobe overlap seen
      int gap;      // idle cycles before this access, -1 = not checked
   } exp_t;

   exp_t sb_q[$];

   mem_seq #(
      .WAIT_CYCLES (1),
      .ADDR_W      (9)
   ) dut (
      .clk    (clk),
      .clr    (clr),
      .req_rd (req_rd),
      .req_wr (req_wr),
      .bus    (bus),
      .MARin  (MARin),
      .MDRin  (MDRin),
      .read   (read),
      .write  (write),
      .busy   (busy),
      .done   (done),
      .err    (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   // Hand-computed expectations for WAIT_CYCLES=1.
   function automatic exp_t exp_load(input int gap);
      exp_t e;
      e = '{lat:4, mar:1, mar_pos:1, rd:2, mdr:1, mdr_pos:3, wr:0, err:0, ovl:0, gap:gap};
      return e;
   endfunction

   function automatic exp_t exp_store(input int gap);
      exp_t e;
      e = '{lat:5, mar:1, mar_pos:1, rd:0, mdr:1, mdr_pos:2, wr:2, err:0, ovl:0, gap:gap};
      return e;
   endfunction

   function automatic exp_t exp_fault();
      exp_t e;
      e = '{lat:2, mar:1, mar_pos:1, rd:0, mdr:0, mdr_pos:0, wr:0, err:1, ovl:0, gap:-1};
      return e;
   endfunction

   function automatic exp_t exp_conflict();
      exp_t e;
      e = '{lat:1, mar:0, mar_pos:0, rd:0, mdr:0, mdr_pos:0, wr:0, err:1, ovl:0, gap:-1};
      return e;
   endfunction

   // Monitor: measures each access from its first busy cycle to done and
   // compares against the oldest queued expectation.
   always @(negedge clk) begin
      static int   active   = 0;
      static int   idle_cnt = 0;
      static exp_t m;
      exp_t e;
      if (!clr) begin
         active   = 0;
         idle_cnt = 0;
      end else if (busy) begin
         if (active == 0) begin
            active = 1;
            m = '{lat:0, mar:0, mar_pos:0, rd:0, mdr:0, mdr_pos:0, wr:0, err:0, ovl:0, gap:idle_cnt};
         end
         m.lat++;
         if (MARin) begin m.mar++; m.mar_pos = m.lat; end
         if (read)  m.rd++;
         if (write) m.wr++;
         if (MDRin) begin m.mdr++; m.mdr_pos = m.lat; end
         if (err)   m.err++;
         if ((read && write) || (MARin && (read || write))) m.ovl = 1;
         if (done) begin
            active   = 0;
            idle_cnt = 0;
            if (sb_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("latency", m.lat, e.lat);
               chk("marin_cycles", m.mar, e.mar);
               chk("marin_pos", m.mar_pos, e.mar_pos);
               chk("read_cycles", m.rd, e.rd);
               chk("mdrin_cycles", m.mdr, e.mdr);
               chk("mdrin_pos", m.mdr_pos, e.mdr_pos);
               chk("write_cycles", m.wr, e.wr);
               chk("err_cycles", m.err, e.err);
               chk("strobe_overlap", m.ovl, e.ovl);
               if (e.gap >= 0) chk("idle_gap", m.gap, e.gap);
            end
         end
      end else begin
         idle_cnt++;
         if (MARin || MDRin || read || write || done || err)
            chk("idle_outputs", 1, 0);
      end
   end

   task automatic wait_idle(input int max_cyc);
      int n;
      n = 0;
      while (busy && n < max_cyc) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_timeout", int'(busy), 0);
   endtask

   // Starts one cycle after a rising edge with the DUT in IDLE.
   task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input exp_t e);
      sb_q.push_back(e);
      req_rd = rd;
      req_wr = wr;
      bus    = addr;
      @(posedge clk); #1;      // accepted; MAR (or ERR) cycle, address stays on bus
      req_rd = 1'b0;
      req_wr = 1'b0;
      @(posedge clk); #1;      // WR_DATA cycle for a store
      bus = data;
      wait_idle(20);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      clr    = 1'b0;
      req_rd = 1'b0;
      req_wr = 1'b0;
      bus    = '0;
      #1;
      chk("reset_outputs", int'({MARin, MDRin, read, write, busy, done, err}), 0);
      repeat (2) @(posedge clk);
      @(negedge clk); #2;
      clr = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_busy", int'(busy), 0);

      // Load, store, address-range boundaries, conflict.
      do_req(1'b1, 1'b0, 32'h0000_0045, 32'h0, exp_load(-1));
      do_req(1'b0, 1'b1, 32'h0000_0045, 32'hDEAD_BEEF, exp_store(-1));
      do_req(1'b1, 1'b0, 32'h0000_0200, 32'h0, exp_fault());
      do_req(1'b1, 1'b0, 32'h0000_01FF, 32'h0, exp_load(-1));
      do_req(1'b0, 1'b1, 32'h8000_0000, 32'h1234_5678, exp_fault());
      do_req(1'b1, 1'b1, 32'h0000_0045, 32'h0, exp_conflict());

      // Requests arriving while busy are dropped.
      sb_q.push_back(exp_load(-1));
      req_rd = 1'b1; bus = 32'h0000_0010;
      @(posedge clk); #1; req_rd = 1'b0;
      @(posedge clk); #1; req_wr = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1; req_wr = 1'b0;
      wait_idle(20);
      repeat (3) @(posedge clk); #1;
      chk("ignored_req_busy", int'(busy), 0);
      chk("ignored_req_queue", sb_q.size(), 0);

      // Reset during the first write cycle.
      req_wr = 1'b1; bus = 32'h0000_0045;
      @(posedge clk); #1; req_wr = 1'b0;
      @(posedge clk); #1; bus = 32'hCAFE_F00D;
      @(posedge clk); #1;
      chk("write_before_reset", int'(write), 1);
      #2 clr = 1'b0;
      #1;
      chk("write_async_drop", int'(write), 0);
      chk("reset_mid_outputs", int'({MARin, MDRin, read, write, busy, done, err}), 0);
      @(negedge clk); #2;
      clr = 1'b1;
      @(posedge clk); #1;
      chk("busy_after_release", int'(busy), 0);
      do_req(1'b1, 1'b0, 32'h0000_0045, 32'h0, exp_load(-1));

      // Request held for 10 cycles: two loads, one idle cycle between them.
      sb_q.push_back(exp_load(-1));
      sb_q.push_back(exp_load(1));
      req_rd = 1'b1; bus = 32'h0000_0045;
      repeat (10) @(posedge clk);
      #1 req_rd = 1'b0;
      wait_idle(20);
      repeat (3) @(posedge clk); #1;
      chk("b2b_busy", int'(busy), 0);
      chk("final_queue_empty", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
